// File: rtl/rr_grant_dispatch_pkg.sv
// rr_grant_pkg: shared request count, index type and dispatcher state encoding
package rr_grant_pkg;
   localparam int N_REQ = 4;
   typedef logic [1:0] req_idx_t;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
endpackage

// File: rtl/rr_grant_dispatch_if.sv
// rr_grant_dispatch_if: request/grant bundle between the requesters and the dispatcher
interface rr_grant_dispatch_if;
   import rr_grant_pkg::*;
   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   req_idx_t         gnt_id;
   logic             busy;
   logic             timeout;
   modport master (output req, done, input gnt, gnt_id, busy, timeout);
   modport slave (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_grant_dispatch_pick.sv
// rr_pick: combinational rotating-priority picker, searching ptr, ptr+1, ... mod 4
module rr_pick
   import rr_grant_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  req_idx_t         i_ptr,
   output logic             o_valid,
   output req_idx_t         o_win
);
   logic [N_REQ-1:0] w_rot;
   req_idx_t         w_off;
   always_comb begin
      w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
      w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
      o_valid = |i_req;
      o_win   = i_ptr + w_off;
   end
endmodule

// File: rtl/rr_grant_dispatch.sv
// rr_grant_dispatch: 4-way round-robin grant FSM; define GRANT_TIMEOUT_EN to bound grants to HOLD_MAX cycles
module rr_grant_dispatch
   import rr_grant_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 5
) (
   input  logic                clk,
   input  logic                rst,
   rr_grant_dispatch_if.slave  bus
);
   state_t           r_state, w_next;
   req_idx_t         r_ptr, r_gnt_id, w_win;
   logic [N_REQ-1:0] r_gnt;
   logic             r_busy, r_timeout;
   logic             w_valid, w_hold, w_to, w_rel;
   rr_pick u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_win   (w_win)
   );
`ifdef GRANT_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst) r_cnt <= '0;
      else r_cnt <= (r_state == GRANT) ? r_cnt + 1'b1 : '0;
   assign w_to = (r_cnt == CNT_W'(HOLD_MAX - 1)) && !bus.done && w_hold;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = |{32'(HOLD_MAX), 32'(CNT_W)};
   assign w_to = 1'b0;
`endif
   always_comb begin
      w_hold = bus.req[r_gnt_id];
      w_rel  = (r_state == GRANT) && (bus.done || !w_hold || w_to);
      w_next = (r_state == IDLE)  ? (w_valid ? GRANT : IDLE) :
               (r_state == GRANT) ? (w_rel ? RELEASE : GRANT) : IDLE;
   end
   // ptr advances only on a real release; reset returns it to requester A
   always_ff @(posedge clk)
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_timeout <= w_rel && w_to;
         if (r_state == IDLE && w_valid) begin
            r_gnt    <= N_REQ'(1) << w_win;
            r_gnt_id <= w_win;
            r_busy   <= 1'b1;
         end else if (w_rel) begin
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= r_gnt_id + 2'd1;
         end
      end
   assign bus.gnt     = r_gnt;
   assign bus.gnt_id  = r_gnt_id;
   assign bus.busy    = r_busy;
   assign bus.timeout = r_timeout;
endmodule

// File: doc/rr_grant_dispatch.md
# rr_grant_dispatch

Four-way round-robin grant dispatcher, the responder side of the registered 4-input OR request collector. Where the collector folds requesters A–D into one registered "any request" line, this block takes the same four request lines, selects exactly one requester, and returns a registered one-hot grant until the holder releases. It sits between the four requesters and the single shared resource they contend for.

## Interface
- HOLD_MAX, 16: maximum grant length in cycles before forced release; must be ≥ 2; used only when timeout is compiled in.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.
- clk  in  1  sole clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- req  in  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive.
- done  in  1  holder's release strobe; ignored when no grant is active.
- gnt  out  4  registered one-hot grant, or all zero.
- gnt_id  out  2  registered binary index of the granted requester; 0 when idle.
- busy  out  1  registered; 1 exactly while gnt≠0.
- timeout  out  1  registered one-cycle pulse on forced release; constant 0 when compiled out.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: if req≠0, pick the winner with rotating priority starting at ptr (ptr, ptr+1, … mod 4), load gnt/gnt_id, go to GRANT; otherwise stay.
- GRANT: release when any of these holds: done=1; req[gnt_id]=0 (abandon); forced timeout. On release: gnt=0, busy=0, ptr=gnt_id+1 mod 4 (2-bit wrap, 3→0), go to RELEASE.
- RELEASE: one mandatory bubble cycle; always goes to IDLE. No grant is issued here, even if req≠0.
- Simultaneous done and holder req drop count as a single release; timeout stays 0 when done=1 in the same cycle.
- Requests from non-holders never affect an active grant.
- Reset values: state=IDLE, ptr=0 (A highest priority), gnt=0, gnt_id=0, busy=0, timeout=0, hold count=0.
- Reset mid-grant: gnt drops at the next edge, with no timeout pulse and no ptr advance (ptr returns to 0).

## Timing
- Grant latency: req sampled in IDLE at edge t → gnt valid after edge t.
- Release: done=1 before edge t → gnt=0 after t; RELEASE during t..t+1; the earliest new grant is visible after edge t+2.
- Back-to-back throughput: one grant per (hold length + 2) cycles minimum.
- All outputs are registered, with no combinational input→output paths.

## Configuration
- GRANT_TIMEOUT_EN defined:
  - A CNT_W hold counter clears on grant entry and increments each GRANT cycle.
  - When it reaches HOLD_MAX-1 with done=0 and req[gnt_id]=1, the block forces a release and asserts timeout for exactly the following cycle (coincident with gnt=0).
  - This bounds any grant to HOLD_MAX cycles.
- Undefined: the counter logic is absent, timeout is tied to 0, HOLD_MAX and CNT_W are unused, and a grant can persist indefinitely.

## Structure
- Shared package rr_grant_pkg holds:
  - N_REQ=4
  - typedef req_idx_t (2-bit)
  - state enum {IDLE, GRANT, RELEASE}
- Sub-module rr_pick: purely combinational rotating-priority picker. Inputs are req[3:0] and ptr; outputs are a valid flag and a 2-bit winner index. Instantiated once.

## Test plan
- Reset then req=4'b1111 → gnt=4'b0001, gnt_id=0 one edge later. After done, the next grant is 4'b0010 two edges after release.
- Only req[2] high with ptr=3 → ptr wraps and gnt=4'b0100. After release, ptr=3; with req=4'b1001, D wins.
- Holder drops req while done=0 → gnt=0 next edge, timeout=0, ptr advances.
- GRANT_TIMEOUT_EN, HOLD_MAX=4, holder keeps req with done=0 → gnt high for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle.
- rst asserted during GRANT with done=1 the same cycle → all outputs 0 next edge, no timeout pulse, next grant uses ptr=0.
- req≠0 during the RELEASE cycle → no grant until the following edge, then rotating priority from the updated ptr.
